// File: rtl/wm_key_panel_if.sv
// Key panel bus: raw keys and run feedback in, selections and run command out.
interface wm_key_panel_if;
  logic       key_course;
  logic       key_water;
  logic       key_temp;
  logic       key_start;
  logic       cycle_done;
  logic [1:0] sel_course;
  logic [1:0] sel_water;
  logic [1:0] sel_temp;
  logic       run;
  logic       sel_changed;

  modport master (
    output key_course, key_water, key_temp, key_start, cycle_done,
    input  sel_course, sel_water, sel_temp, run, sel_changed
  );

  modport slave (
    input  key_course, key_water, key_temp, key_start, cycle_done,
    output sel_course, sel_water, sel_temp, run, sel_changed
  );
endinterface

// File: rtl/wm_key_panel.sv
// Washing-machine key panel: per-key synchronise/debounce lanes feeding
// selection registers and a two-state run controller.
module wm_key_lane #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_vld,
  input  logic key_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          deb;
  logic          armed;
  logic [CW-1:0] cnt;

  // armed only once the key has been seen released after reset, so a key
  // held through reset cannot produce a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      deb   <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      if (sync_vld && !sync[1]) armed <= 1'b1;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb   <= ~deb;
        cnt   <= '0;
        press <= ~deb & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module wm_key_panel #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic           clk,
  input  logic           reset,
  wm_key_panel_if.slave  bus
);
  localparam int NUM_KEYS = 4;
  localparam int K_COURSE = 0;
  localparam int K_WATER  = 1;
  localparam int K_TEMP   = 2;
  localparam int K_START  = 3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_state_t;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic [2:1]          vld_pipe;
  run_state_t          state, state_nxt;
  logic [1:0]          course_q, water_q, temp_q;
  logic [1:0]          course_nxt, water_nxt, temp_nxt;
  logic                changed_q, changed_nxt;

  assign key_raw = {bus.key_start, bus.key_temp, bus.key_water, bus.key_course};

  // Marks when the synchroniser output reflects post-reset samples.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1], 1'b1};
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    wm_key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .sync_vld (vld_pipe[2]),
      .key_raw  (key_raw[i]),
      .press    (press[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    course_nxt  = course_q;
    water_nxt   = water_q;
    temp_nxt    = temp_q;
    changed_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press[K_START]) state_nxt = RUN;
        if (press[K_COURSE]) begin
          course_nxt  = course_q + 2'd1;
          changed_nxt = 1'b1;
        end
        if (press[K_WATER]) begin
          water_nxt   = (water_q == 2'd2) ? 2'd0 : water_q + 2'd1;
          changed_nxt = 1'b1;
        end
        if (press[K_TEMP]) begin
          temp_nxt    = (temp_q == 2'd2) ? 2'd0 : temp_q + 2'd1;
          changed_nxt = 1'b1;
        end
      end
      RUN: begin
        if (press[K_START] || bus.cycle_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      course_q  <= 2'd0;
      water_q   <= 2'd0;
      temp_q    <= 2'd0;
      changed_q <= 1'b0;
    end else begin
      course_q  <= course_nxt;
      water_q   <= water_nxt;
      temp_q    <= temp_nxt;
      changed_q <= changed_nxt;
    end
  end

  assign bus.sel_course  = course_q;
  assign bus.sel_water   = water_q;
  assign bus.sel_temp    = temp_q;
  assign bus.run         = (state == RUN);
  assign bus.sel_changed = changed_q;
endmodule

// File: tb/tb_wm_key_panel.sv
// Bench for wm_key_panel: directed scenarios plus random key activity
// checked every cycle against a window-based behavioural model.
module tb_wm_key_panel;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys = '0;
  logic       cycle_done = 1'b0;

  wm_key_panel_if bus();
  assign bus.key_course = keys[0];
  assign bus.key_water  = keys[1];
  assign bus.key_temp   = keys[2];
  assign bus.key_start  = keys[3];
  assign bus.cycle_done = cycle_done;

  wm_key_panel #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // Model: a key's debounced level flips once the last D synchronised samples
  // all disagree with it; synchronised sample = raw level two edges earlier.
  int         n_edge = 0;
  logic [3:0] r1 = '0, r2 = '0;
  logic [D-1:0] win [4];
  logic [3:0] deb_m = '0, seen_low = '0, ev = '0;
  int         m_course = 0, m_water = 0, m_temp = 0;
  bit         m_run = 1'b0, m_chg = 1'b0;

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] ev_new;
    bit chg, old_run;
    if (reset) begin
      n_edge = 0; r1 = '0; r2 = '0; deb_m = '0; seen_low = '0; ev = '0;
      for (int k = 0; k < 4; k++) win[k] = '0;
      m_course = 0; m_water = 0; m_temp = 0; m_run = 1'b0; m_chg = 1'b0;
      return;
    end
    n_edge++;
    chg = 1'b0;
    old_run = m_run;
    if (!old_run) begin
      if (ev[0]) begin m_course = (m_course + 1) % 4; chg = 1'b1; end
      if (ev[1]) begin m_water  = (m_water + 1) % 3;  chg = 1'b1; end
      if (ev[2]) begin m_temp   = (m_temp + 1) % 3;   chg = 1'b1; end
      if (ev[3]) m_run = 1'b1;
    end else if (ev[3] || cycle_done) begin
      m_run = 1'b0;
    end
    m_chg = chg;
    s = r2; r2 = r1; r1 = keys;
    ev_new = '0;
    for (int k = 0; k < 4; k++) begin
      win[k] = {win[k][D-2:0], s[k]};
      if (win[k] == {D{~deb_m[k]}}) begin
        deb_m[k] = ~deb_m[k];
        if (deb_m[k] && seen_low[k]) ev_new[k] = 1'b1;
      end
      if (n_edge >= 3 && !s[k]) seen_low[k] = 1'b1;
    end
    ev = ev_new;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      checks++;
      if (bus.sel_course !== 2'(m_course) || bus.sel_water !== 2'(m_water) ||
          bus.sel_temp !== 2'(m_temp) || bus.run !== m_run || bus.sel_changed !== m_chg) begin
        failures++;
        $display("FAIL outputs @%0t: got c%0d w%0d t%0d run%0d chg%0d expected c%0d w%0d t%0d run%0d chg%0d",
                 $time, bus.sel_course, bus.sel_water, bus.sel_temp, bus.run, bus.sel_changed,
                 m_course, m_water, m_temp, m_run, m_chg);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(int k, int hold);
    @(negedge clk);
    keys[k] = 1'b1;
    repeat (hold) @(negedge clk);
    keys[k] = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  int first_a, first_b, pulses;
  int temp_exp [5] = '{1, 2, 0, 1, 2};
  int course_exp [4] = '{1, 2, 3, 0};
  int hold [4] = '{0, 0, 0, 0};

  initial begin
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_course", bus.sel_course, 0);
    chk("rst_water", bus.sel_water, 0);
    chk("rst_temp", bus.sel_temp, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_chg", bus.sel_changed, 0);
    repeat (4) @(negedge clk);

    // Clean water press: update on edge 19 with a single change pulse.
    first_a = 0; pulses = 0;
    keys[1] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (first_a == 0 && bus.sel_water != 2'd0) first_a = n;
      if (bus.sel_changed) pulses++;
    end
    chk("water_edge", first_a, 19);
    chk("water_val", bus.sel_water, 1);
    chk("water_pulses", pulses, 1);
    chk("water_course", bus.sel_course, 0);
    chk("water_run", bus.run, 0);
    @(negedge clk);
    keys[1] = 1'b0;
    repeat (25) @(negedge clk);

    // Bouncing course key never settles long enough.
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      if (n % 5 == 0) keys[0] = ~keys[0];
      @(negedge clk);
      if (bus.sel_changed) pulses++;
    end
    keys[0] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.sel_changed) pulses++;
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_course", bus.sel_course, 0);

    for (int i = 0; i < 5; i++) begin
      press(2, 25);
      chk("temp_seq", bus.sel_temp, temp_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      press(0, 25);
      chk("course_seq", bus.sel_course, course_exp[i]);
    end

    // Run control.
    press(3, 25);
    chk("start_run", bus.run, 1);
    press(1, 25);
    chk("run_water_locked", bus.sel_water, 1);
    @(negedge clk); cycle_done = 1'b1;
    @(negedge clk); cycle_done = 1'b0;
    chk("done_run", bus.run, 0);
    press(3, 25);
    chk("start2_run", bus.run, 1);
    @(negedge clk);
    keys[3] = 1'b1;
    repeat (18) @(negedge clk);
    cycle_done = 1'b1;
    @(negedge clk);
    cycle_done = 1'b0;
    chk("coinc_run", bus.run, 0);
    repeat (10) @(negedge clk);
    keys[3] = 1'b0;
    repeat (25) @(negedge clk);
    chk("coinc_run_hold", bus.run, 0);

    // Course and start together from idle land on the same edge.
    first_a = 0; first_b = 0;
    keys[0] = 1'b1; keys[3] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (first_a == 0 && bus.sel_course != 2'd0) first_a = n;
      if (first_b == 0 && bus.run) first_b = n;
    end
    chk("sim_course_edge", first_a, 19);
    chk("sim_run_edge", first_b, 19);
    chk("sim_course", bus.sel_course, 1);
    @(negedge clk);
    keys[0] = 1'b0; keys[3] = 1'b0;
    repeat (25) @(negedge clk);

    // Reset mid-debounce while running; held key must not fire afterwards.
    keys[0] = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_course", bus.sel_course, 0);
    chk("mid_rst_run", bus.run, 0);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.sel_changed) pulses++;
    end
    chk("held_pulses", pulses, 0);
    chk("held_course", bus.sel_course, 0);
    keys[0] = 1'b0;
    repeat (25) @(negedge clk);
    press(0, 25);
    chk("repress_course", bus.sel_course, 1);

    // Random key activity, cycle_done pulses and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          keys[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12))
                                                : int'($urandom_range(17, 45));
        end else begin
          hold[k]--;
        end
      end
      cycle_done = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    cycle_done = 1'b0; reset = 1'b0; keys = '0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
